// File: rtl/led_seq_ctrl.sv
`default_nettype none
// led_seq_ctrl: button-stepped LED display, either idle, a rotating dot, or the sum of two 4-bit operands.
// Optional build macro: LED_SEQ_PINGPONG_EN makes the rotating dot bounce between the end positions.
module led_seq_ctrl #(
  parameter int TICK_DIV = 6000000,
  parameter int DEB_CYC  = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic [4:0] led,
  output logic [1:0] mode
);
  localparam logic [24:0] c_TICK_LAST = 25'(TICK_DIV - 1);
  localparam logic [19:0] c_DEB_LAST  = 20'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_SUM    = 2'd2
  } state_t;

  logic        r_btn_s1, r_btn_s2, r_vld_s1, r_vld_s2;
  logic [3:0]  r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic        r_deb, r_armed, r_press;
  logic [19:0] r_deb_cnt;
  state_t      r_state;
  logic [24:0] r_pre;
  logic [1:0]  r_pos;
  logic [3:0]  r_cap_a, r_cap_b;
`ifdef LED_SEQ_PINGPONG_EN
  logic        r_dir;
`endif
  logic        w_tick;
  state_t      w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_vld_s1 <= 1'b0;
      r_vld_s2 <= 1'b0;
      r_a_s1   <= '0;
      r_a_s2   <= '0;
      r_b_s1   <= '0;
      r_b_s2   <= '0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_vld_s1 <= 1'b1;
      r_vld_s2 <= r_vld_s1;
      r_a_s1   <= op_a;
      r_a_s2   <= r_a_s1;
      r_b_s1   <= op_b;
      r_b_s2   <= r_b_s1;
    end
  end

  // Presses are only honoured once the synchronized button has been seen low after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_armed <= r_armed | (r_vld_s2 & ~r_btn_s2);
      if (r_btn_s2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_DEB_LAST) begin
        r_deb     <= r_btn_s2;
        r_deb_cnt <= '0;
        r_press   <= r_btn_s2 & r_armed;
      end else begin
        r_deb_cnt <= r_deb_cnt + 20'd1;
      end
    end
  end

  assign w_tick = (r_pre == c_TICK_LAST);

  always_comb begin
    w_next = S_ROTATE;
    case (r_state)
      S_IDLE:   w_next = S_ROTATE;
      S_ROTATE: w_next = S_SUM;
      S_SUM:    w_next = S_IDLE;
      default:  w_next = S_ROTATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_pos   <= '0;
      r_cap_a <= '0;
      r_cap_b <= '0;
`ifdef LED_SEQ_PINGPONG_EN
      r_dir   <= 1'b0;
`endif
      led     <= '0;
      mode    <= '0;
    end else begin
      if (r_press) begin
        // A press outranks a coincident tick.
        r_state <= w_next;
        r_pre   <= '0;
        r_pos   <= '0;
`ifdef LED_SEQ_PINGPONG_EN
        r_dir   <= 1'b0;
`endif
        if (w_next == S_SUM) begin
          r_cap_a <= r_a_s2;
          r_cap_b <= r_b_s2;
        end
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 25'd1;
        if (w_tick) begin
          case (r_state)
            S_ROTATE: begin
`ifdef LED_SEQ_PINGPONG_EN
              if (!r_dir) begin
                if (r_pos == 2'd3) begin
                  r_pos <= 2'd2;
                  r_dir <= 1'b1;
                end else begin
                  r_pos <= r_pos + 2'd1;
                end
              end else begin
                if (r_pos == 2'd0) begin
                  r_pos <= 2'd1;
                  r_dir <= 1'b0;
                end else begin
                  r_pos <= r_pos - 2'd1;
                end
              end
`else
              r_pos <= r_pos + 2'd1;
`endif
            end
            S_SUM: begin
              r_cap_a <= r_a_s2;
              r_cap_b <= r_b_s2;
            end
            default: ;
          endcase
        end
      end

      case (r_state)
        S_ROTATE: begin
          led  <= {1'b0, 4'b0001 << r_pos};
          mode <= S_ROTATE;
        end
        S_SUM: begin
          led  <= {1'b0, r_cap_a} + {1'b0, r_cap_b};
          mode <= S_SUM;
        end
        default: begin
          led  <= '0;
          mode <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
